// File: rtl/mem_arb.sv
// mem_arb: two-master arbiter onto a single shared memory request/response port.
//
// Masters:
//   m0 : instruction-fetch path (read-only in practice, m0_req_wen tied low by the ifu)
//   m1 : load/store path
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   mX_req_vld/rdy/addr/wen/wdata/wstrb
//                               master request channels (valid/ready)
//   mX_rsp_vld/rdy/rdata        master response channels (rdata shared from slave)
//   s_req_vld/rdy/addr/wen/wdata/wstrb
//                               shared-port request, payload muxed from the granted master
//   s_rsp_vld/rdy/rdata         shared-port response, routed by the in-order owner FIFO
//   proto_err                   sticky: response seen with nothing outstanding
//
// Build option:
//   MEM_ARB_RR_EN  defined   -> round-robin arbitration with a 1-bit last-grant pointer
//                  undefined -> fixed priority, m1 over m0
module mem_arb #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            m0_req_vld,
    output logic            m0_req_rdy,
    input  logic [AW-1:0]   m0_req_addr,
    input  logic            m0_req_wen,
    input  logic [DW-1:0]   m0_req_wdata,
    input  logic [DW/8-1:0] m0_req_wstrb,
    output logic            m0_rsp_vld,
    input  logic            m0_rsp_rdy,
    output logic [DW-1:0]   m0_rsp_rdata,

    input  logic            m1_req_vld,
    output logic            m1_req_rdy,
    input  logic [AW-1:0]   m1_req_addr,
    input  logic            m1_req_wen,
    input  logic [DW-1:0]   m1_req_wdata,
    input  logic [DW/8-1:0] m1_req_wstrb,
    output logic            m1_rsp_vld,
    input  logic            m1_rsp_rdy,
    output logic [DW-1:0]   m1_rsp_rdata,

    output logic            s_req_vld,
    input  logic            s_req_rdy,
    output logic [AW-1:0]   s_req_addr,
    output logic            s_req_wen,
    output logic [DW-1:0]   s_req_wdata,
    output logic [DW/8-1:0] s_req_wstrb,
    input  logic            s_rsp_vld,
    output logic            s_rsp_rdy,
    input  logic [DW-1:0]   s_rsp_rdata,

    output logic            proto_err
);

    localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CW = $clog2(OUTSTANDING + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(OUTSTANDING - 1);
    localparam logic [CW-1:0] MAX_CNT  = CW'(OUTSTANDING);

    // owner FIFO: one bit per outstanding request, 0 = m0, 1 = m1
    logic [OUTSTANDING-1:0] r_owner;
    logic [PW-1:0]          r_wr_ptr;
    logic [PW-1:0]          r_rd_ptr;
    logic [CW-1:0]          r_cnt;
    logic                   r_hold;
    logic                   r_hold_id;
    logic                   r_proto_err;

    logic w_full;
    logic w_cnt_nz;
    logic w_sel;
    logic w_req_any;
    logic w_s_req_vld;
    logic w_req_hs;
    logic w_head;
    logic w_s_rsp_rdy;
    logic w_pop;
    logic w_drop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign w_full    = (r_cnt == MAX_CNT);
    assign w_cnt_nz  = (r_cnt != '0);
    assign w_req_any = m0_req_vld | m1_req_vld;

`ifdef MEM_ARB_RR_EN
    logic r_last;

    always_comb begin
        w_sel = 1'b0;
        if (r_hold) begin
            w_sel = r_hold_id;
        end else if (m0_req_vld & m1_req_vld) begin
            w_sel = ~r_last;
        end else begin
            w_sel = m1_req_vld;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= 1'b0;
        end else if (w_req_hs) begin
            r_last <= w_sel;
        end
    end
`else
    always_comb begin
        w_sel = 1'b0;
        if (r_hold) begin
            w_sel = r_hold_id;
        end else begin
            w_sel = m1_req_vld;
        end
    end
`endif

    // No bypass: a pop in the same cycle does not free a slot for a new request.
    assign w_s_req_vld = w_req_any & ~w_full;
    assign w_req_hs    = w_s_req_vld & s_req_rdy;

    assign w_head      = r_owner[r_rd_ptr];
    assign w_s_rsp_rdy = w_cnt_nz ? (w_head ? m1_rsp_rdy : m0_rsp_rdy) : 1'b1;
    assign w_pop       = s_rsp_vld & w_s_rsp_rdy & w_cnt_nz;
    assign w_drop      = s_rsp_vld & ~w_cnt_nz;

    // Handshake outputs are forced low while reset is asserted.
    assign s_req_vld   = w_s_req_vld & ~rst;
    assign m0_req_rdy  = ~w_sel & s_req_rdy & ~w_full & ~rst;
    assign m1_req_rdy  =  w_sel & s_req_rdy & ~w_full & ~rst;

    assign s_req_addr  = w_sel ? m1_req_addr  : m0_req_addr;
    assign s_req_wen   = w_sel ? m1_req_wen   : m0_req_wen;
    assign s_req_wdata = w_sel ? m1_req_wdata : m0_req_wdata;
    assign s_req_wstrb = w_sel ? m1_req_wstrb : m0_req_wstrb;

    assign m0_rsp_vld   = s_rsp_vld & w_cnt_nz & ~w_head & ~rst;
    assign m1_rsp_vld   = s_rsp_vld & w_cnt_nz &  w_head & ~rst;
    assign s_rsp_rdy    = w_s_rsp_rdy & ~rst;
    assign m0_rsp_rdata = s_rsp_rdata;
    assign m1_rsp_rdata = s_rsp_rdata;

    assign proto_err = r_proto_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cnt       <= '0;
            r_hold      <= 1'b0;
            r_hold_id   <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_req_hs) begin
                r_owner[r_wr_ptr] <= w_sel;
                r_wr_ptr          <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_req_hs & ~w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_pop & ~w_req_hs) begin
                r_cnt <= r_cnt - 1'b1;
            end

            // Freeze the grant while the slave back-pressures so the payload stays stable.
            if (w_req_hs) begin
                r_hold <= 1'b0;
            end else if (w_s_req_vld) begin
                r_hold    <= 1'b1;
                r_hold_id <= w_sel;
            end

            if (w_drop) begin
                r_proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Arbitrates two fetch/load-store requesters onto one shared memory port using req/rsp valid-ready handshakes.
  - Master 0 is the instruction-fetch path (ifu side).
  - Master 1 is the load/store path.
- Tracks outstanding requests in an in-order owner FIFO and steers each slave response back to the master that issued it.
- Sits between the core front-end/LSU and the single-ported memory or bus bridge.

Parameters:
AW, 32, address width
DW, 32, data width
OUTSTANDING, 2, max requests accepted by slave but not yet responded (>=1)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
m0_req_vld / m1_req_vld  input  1  master request valid
m0_req_rdy / m1_req_rdy  output  1  master request ready
m0_req_addr / m1_req_addr  input  AW  request address
m0_req_wen / m1_req_wen  input  1  1=write, 0=read (ifu ties m0 to 0)
m0_req_wdata / m1_req_wdata  input  DW  write data
m0_req_wstrb / m1_req_wstrb  input  DW/8  byte strobes
m0_rsp_vld / m1_rsp_vld  output  1  response valid to master
m0_rsp_rdy / m1_rsp_rdy  input  1  master accepts response
m0_rsp_rdata / m1_rsp_rdata  output  DW  read data (both driven from s_rsp_rdata)
s_req_vld  output  1  request to shared port
s_req_rdy  input  1  shared port accepts request
s_req_addr, s_req_wen, s_req_wdata, s_req_wstrb  output  AW/1/DW/DW/8  muxed payload
s_rsp_vld  input  1  shared port response valid
s_rsp_rdy  output  1  response ready to shared port
s_rsp_rdata  input  DW  response data
proto_err  output  1  sticky: response arrived with no outstanding request

Behaviour:
- Reset is asynchronous and active-high: clk is the only clock, and rst asynchronously clears all state.
  - Reset state: owner FIFO empty, count=0, hold cleared, rr pointer=m0, proto_err=0.
  - While rst is high, all *_vld and *_rdy outputs are 0.
- full = (count==OUTSTANDING). Requests are blocked whenever full, even if a pop happens in the same cycle (no bypass).
- s_req_vld = (m0_req_vld | m1_req_vld) & ~full. The payload is muxed from the selected master `sel`.
- Selection:
  - If hold=1, sel=hold_id.
  - Otherwise the arbitration policy picks sel among the valid masters.
  - Default policy: fixed priority, m1 over m0.
- mX_req_rdy = (sel==X) & s_req_rdy & ~full. The loser's rdy stays 0.
- Hold (keeps the payload stable under backpressure): if s_req_vld & ~s_req_rdy, then hold<=1 and hold_id<=sel. Hold clears on the next s_req handshake.
  - Masters must keep vld asserted until accepted. Deassertion while held is a master protocol violation and is not handled.
- Request handshake (s_req_vld & s_req_rdy): push sel into the owner FIFO, count+1. Zero latency: a combinational pass-through of the payload, no extra cycle.
- Response routing:
  - head = FIFO head owner.
  - mX_rsp_vld = s_rsp_vld & (count!=0) & (head==X).
  - s_rsp_rdy = (count==0) ? 1 : rsp_rdy of the head master.
- Response handshake with count!=0: pop the FIFO, count-1.
- Simultaneous push and pop: count unchanged. FIFO read/write pointers wrap modulo OUTSTANDING.
- s_rsp_vld with count==0: the response is accepted and dropped (s_rsp_rdy=1), no master vld, proto_err<=1. proto_err stays set until reset.
- The slave returns responses in request order. No reordering is supported.
- Reset asserted mid-transaction discards all outstanding ownership. Responses after reset set proto_err.

Optional Feature:
- MEM_ARB_RR_EN defined:
  - Round-robin arbitration with a 1-bit last-grant pointer, updated on each s_req handshake to the granted master.
  - When both masters are valid and hold=0, grant the master not equal to the pointer.
  - The pointer resets to m0, so the first contention grants m1.
- MEM_ARB_RR_EN undefined: fixed priority m1 > m0, and the pointer logic is absent.

Test Plan:
- Single m0 read, addr 0x0000_0004, s_req_rdy=1 → s_req_vld same cycle, m0_req_rdy=1, count=1.
  - Then s_rsp_vld with rdata 0x0000_0013 → m0_rsp_vld=1, rdata 0x13, count=0.
- Both request, s_req_rdy=1 (fixed priority) → m1 granted first, m0 next cycle. Owner FIFO holds [1,0], and responses route to m1 then m0.
- m0 alone valid, s_req_rdy=0 for 3 cycles, then m1 raises vld → grant stays m0 (hold), addr stable. m0 is accepted when s_req_rdy=1, then m1 is served.
- OUTSTANDING=2, three back-to-back m0 requests with no responses → first two accepted, third m0_req_rdy=0.
  - A response plus the third request in the same cycle → the third request is still blocked that cycle and accepted the next.
- s_rsp_vld=1 with count=0 → s_rsp_rdy=1, m0/m1_rsp_vld=0, proto_err=1 and held until rst pulse.
- MEM_ARB_RR_EN, both masters valid continuously for 4 accepts → grant order m1,m0,m1,m0.
  - Without the macro, the same stimulus gives m1,m1,m1,m1.
